clock_group_reset_sequencer: RTL and testbench

//  Parametrised successor to the pass-through clock-group aggregator. Fans one upstream clock

---
 rtl/clock_group_reset_sequencer.sv | 177 +++++++++++++++++
 tb/tb_clock_group_reset_sequencer.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/clock_group_reset_sequencer.sv
// Fans one upstream clock group out to NUM_GROUPS members, sequencing each member's clock
// enable and synchronous reset in index order with a fixed stagger, plus park/release/shutdown.
module clock_group_reset_sequencer #(
  parameter int unsigned NUM_GROUPS     = 2,
  parameter int unsigned STAGGER_CYCLES = 4,
  parameter int unsigned CNT_W          = 8,
  parameter int unsigned SYNC_STAGES    = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  in_reset,
  input  logic [NUM_GROUPS-1:0] hold_req,
  output logic [NUM_GROUPS-1:0] out_clock_en,
  output logic [NUM_GROUPS-1:0] out_reset,
  output logic                  all_ready,
  output logic                  seq_busy
);

  localparam int unsigned IdxW = (NUM_GROUPS > 1) ? $clog2(NUM_GROUPS) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_GROUPS - 1);
  localparam logic [CNT_W-1:0] CntLast = CNT_W'(STAGGER_CYCLES - 1);

  typedef enum logic [2:0] {
    StHold, StEnWait, StRstWait, StRun, StGOff, StGOnEn, StGOnRst, StShut
  } state_e;

  state_e                 state_q, state_d;
  logic [IdxW-1:0]        idx_q, idx_d, nxt_idx, chg_idx;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [NUM_GROUPS-1:0]  held_q, held_d;
  logic [NUM_GROUPS-1:0]  clk_en_q, clk_en_d;
  logic [NUM_GROUPS-1:0]  rst_q, rst_d;
  logic                   all_ready_q, all_ready_d;
  logic                   seq_busy_q, seq_busy_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s_rst, phase_done, enter, need_change;

  assign s_rst      = sync_q[SYNC_STAGES-1];
  assign phase_done = (cnt_q == CntLast);
  assign nxt_idx    = idx_q + IdxW'(1);

  // Lowest-index group whose hold request disagrees with its current parked state.
  always_comb begin
    need_change = 1'b0;
    chg_idx     = '0;
    for (int i = int'(NUM_GROUPS) - 1; i >= 0; i--) begin
      if (hold_req[i] != held_q[i]) begin
        need_change = 1'b1;
        chg_idx     = IdxW'(i);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    held_d   = held_q;
    clk_en_d = clk_en_q;
    rst_d    = rst_q;
    enter    = 1'b0;
    if (s_rst && (state_q != StHold) && (state_q != StShut)) begin
      state_d = StShut;
      rst_d   = '1;
      held_d  = '1;
      enter   = 1'b1;
    end else begin
      unique case (state_q)
        StHold: begin
          if (!s_rst) begin
            state_d     = StEnWait;
            idx_d       = '0;
            clk_en_d[0] = !hold_req[0];
            enter       = 1'b1;
          end
        end
        StEnWait, StRstWait: begin
          // A group whose clock was not enabled on entry is being skipped.
          if ((state_q == StEnWait) && clk_en_q[idx_q] && phase_done) begin
            rst_d[idx_q]  = 1'b0;
            held_d[idx_q] = 1'b0;
            state_d       = StRstWait;
            enter         = 1'b1;
          end else if ((state_q == StEnWait && !clk_en_q[idx_q]) ||
                       (state_q == StRstWait && phase_done)) begin
            enter = 1'b1;
            if (idx_q == LastIdx) begin
              state_d = StRun;
            end else begin
              state_d           = StEnWait;
              idx_d             = nxt_idx;
              clk_en_d[nxt_idx] = !hold_req[nxt_idx];
            end
          end
        end
        StRun: begin
          if (need_change) begin
            idx_d = chg_idx;
            enter = 1'b1;
            if (hold_req[chg_idx]) begin
              state_d         = StGOff;
              rst_d[chg_idx]  = 1'b1;
              held_d[chg_idx] = 1'b1;
            end else begin
              state_d           = StGOnEn;
              clk_en_d[chg_idx] = 1'b1;
            end
          end
        end
        StGOff: begin
          if (phase_done) begin
            clk_en_d[idx_q] = 1'b0;
            state_d         = StRun;
            enter           = 1'b1;
          end
        end
        StGOnEn: begin
          if (phase_done) begin
            rst_d[idx_q]  = 1'b0;
            held_d[idx_q] = 1'b0;
            state_d       = StGOnRst;
            enter         = 1'b1;
          end
        end
        StGOnRst: begin
          if (phase_done) begin
            state_d = StRun;
            enter   = 1'b1;
          end
        end
        StShut: begin
          if (phase_done) begin
            clk_en_d = '0;
            state_d  = StHold;
            enter    = 1'b1;
          end
        end
        default: begin
          state_d = StHold;
          enter   = 1'b1;
        end
      endcase
    end
    cnt_d       = enter ? '0 : (phase_done ? cnt_q : cnt_q + CNT_W'(1));
    all_ready_d = (state_d == StRun) && (held_d == '0);
    seq_busy_d  = (state_d != StRun) && (state_d != StHold);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync_q      <= '1;
      state_q     <= StHold;
      idx_q       <= '0;
      cnt_q       <= '0;
      held_q      <= '1;
      clk_en_q    <= '0;
      rst_q       <= '1;
      all_ready_q <= 1'b0;
      seq_busy_q  <= 1'b0;
    end else begin
      sync_q      <= {sync_q[SYNC_STAGES-2:0], in_reset};
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      held_q      <= held_d;
      clk_en_q    <= clk_en_d;
      rst_q       <= rst_d;
      all_ready_q <= all_ready_d;
      seq_busy_q  <= seq_busy_d;
    end
  end

  assign out_clock_en = clk_en_q;
  assign out_reset    = rst_q;
  assign all_ready    = all_ready_q;
  assign seq_busy     = seq_busy_q;

endmodule

// File: tb/tb_clock_group_reset_sequencer.sv
// Scoreboard bench: stimulus queues hand-computed output changes (cycle + value); monitors pop
// and compare whenever a DUT's outputs change, and check the enable/reset invariant each cycle.
module tb_clock_group_reset_sequencer;

  typedef struct {
    int         cyc;
    logic [9:0] v;
  } ev_t;

  logic       clock;
  logic       reset, in_reset;
  logic [1:0] hold_req, ce2, rs2;
  logic       ar2, bz2;
  logic       reset4, in_reset4;
  logic [3:0] hold_req4, ce4, rs4;
  logic       ar4, bz4;
  logic [9:0] snap2, snap4;

  int  cyc = 0;
  int  n_checks = 0;
  int  n_fail = 0;
  ev_t q2[$];
  ev_t q4[$];

  clock_group_reset_sequencer #(
    .NUM_GROUPS(2), .STAGGER_CYCLES(4), .CNT_W(8), .SYNC_STAGES(2)
  ) dut2 (
    .clock(clock), .reset(reset), .in_reset(in_reset), .hold_req(hold_req),
    .out_clock_en(ce2), .out_reset(rs2), .all_ready(ar2), .seq_busy(bz2)
  );

  clock_group_reset_sequencer #(
    .NUM_GROUPS(4), .STAGGER_CYCLES(1), .CNT_W(8), .SYNC_STAGES(2)
  ) dut4 (
    .clock(clock), .reset(reset4), .in_reset(in_reset4), .hold_req(hold_req4),
    .out_clock_en(ce4), .out_reset(rs4), .all_ready(ar4), .seq_busy(bz4)
  );

  assign snap2 = {2'b00, ce2, 2'b00, rs2, ar2, bz2};
  assign snap4 = {ce4, rs4, ar4, bz4};

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(string name, logic [9:0] got, logic [9:0] req);
    n_checks++;
    if (got !== req) begin
      n_fail++;
      $display("FAIL %s: got %b required %b", name, got, req);
    end
  endtask

  task automatic cmp_ev(string name, ev_t e, int c, logic [9:0] got);
    n_checks++;
    if (e.cyc != c || e.v !== got) begin
      n_fail++;
      $display("FAIL %s event: got cyc=%0d val=%b required cyc=%0d val=%b",
               name, c, got, e.cyc, e.v);
    end
  endtask

  task automatic e2(int c, logic [1:0] ce, logic [1:0] rs, logic ar, logic bz);
    q2.push_back('{c, {2'b00, ce, 2'b00, rs, ar, bz}});
  endtask

  task automatic e4(int c, logic [3:0] ce, logic [3:0] rs, logic ar, logic bz);
    q4.push_back('{c, {ce, rs, ar, bz}});
  endtask

  task automatic bringup2(int b);
    e2(b + 3, 2'b01, 2'b11, 1'b0, 1'b1);
    e2(b + 7, 2'b01, 2'b10, 1'b0, 1'b1);
    e2(b + 11, 2'b11, 2'b10, 1'b0, 1'b1);
    e2(b + 15, 2'b11, 2'b00, 1'b0, 1'b1);
    e2(b + 19, 2'b11, 2'b00, 1'b1, 1'b0);
  endtask

  task automatic tick(int n);
    repeat (n) @(negedge clock);
  endtask

  // Monitors: every output change must match the next queued expectation.
  logic [9:0] prev2, prev4;
  bit seen2 = 0, seen4 = 0;

  always @(negedge clock) begin : mon2
    ev_t e;
    n_checks++;
    if ((~rs2 & ~ce2) != 2'b00) begin
      n_fail++;
      $display("FAIL dut2 invariant cyc=%0d: ce=%b rs=%b required no rs=0 with ce=0", cyc, ce2, rs2);
    end
    if (seen2 && snap2 !== prev2) begin
      if (q2.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL dut2 unexpected event: got cyc=%0d val=%b required no change", cyc, snap2);
      end else begin
        e = q2.pop_front();
        cmp_ev("dut2", e, cyc, snap2);
      end
    end
    prev2 = snap2;
    seen2 = 1;
  end

  always @(negedge clock) begin : mon4
    ev_t e;
    n_checks++;
    if ((~rs4 & ~ce4) != 4'b0000) begin
      n_fail++;
      $display("FAIL dut4 invariant cyc=%0d: ce=%b rs=%b required no rs=0 with ce=0", cyc, ce4, rs4);
    end
    if (seen4 && snap4 !== prev4) begin
      if (q4.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL dut4 unexpected event: got cyc=%0d val=%b required no change", cyc, snap4);
      end else begin
        e = q4.pop_front();
        cmp_ev("dut4", e, cyc, snap4);
      end
    end
    prev4 = snap4;
    seen4 = 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int b, d;
    reset = 1'b1; reset4 = 1'b1; in_reset = 1'b1; in_reset4 = 1'b1;
    hold_req = 2'b00; hold_req4 = 4'b0000;
    #1 reset = 1'b0; reset4 = 1'b0;
    #2;
    chk("reset dut2", snap2, 10'b00_00_00_11_0_0);
    chk("reset dut4", snap4, 10'b0000_1111_0_0);
    tick(2);
    reset = 1'b1; reset4 = 1'b1;
    tick(2);

    // Bring-up.
    b = cyc; in_reset = 1'b0; bringup2(b);
    tick(22);
    // Park group 1.
    b = cyc; hold_req = 2'b10;
    e2(b + 1, 2'b11, 2'b10, 1'b0, 1'b1);
    e2(b + 5, 2'b01, 2'b10, 1'b0, 1'b0);
    tick(8);
    // Release group 1.
    b = cyc; hold_req = 2'b00;
    e2(b + 1, 2'b11, 2'b10, 1'b0, 1'b1);
    e2(b + 5, 2'b11, 2'b00, 1'b0, 1'b1);
    e2(b + 9, 2'b11, 2'b00, 1'b1, 1'b0);
    tick(12);
    // Shutdown from RUN, then again during EN_WAIT of group 1.
    b = cyc; in_reset = 1'b1;
    e2(b + 3, 2'b11, 2'b11, 1'b0, 1'b1);
    e2(b + 7, 2'b00, 2'b11, 1'b0, 1'b0);
    tick(10);
    b = cyc; in_reset = 1'b0;
    e2(b + 3, 2'b01, 2'b11, 1'b0, 1'b1);
    e2(b + 7, 2'b01, 2'b10, 1'b0, 1'b1);
    e2(b + 11, 2'b11, 2'b10, 1'b0, 1'b1);
    tick(11);
    b = cyc; in_reset = 1'b1;
    e2(b + 3, 2'b11, 2'b11, 1'b0, 1'b1);
    e2(b + 7, 2'b00, 2'b11, 1'b0, 1'b0);
    tick(10);
    chk("busy low in HOLD", {9'd0, bz2}, 10'd0);
    // Group 0 held through bring-up, then released.
    b = cyc; hold_req = 2'b01; in_reset = 1'b0;
    e2(b + 3, 2'b00, 2'b11, 1'b0, 1'b1);
    e2(b + 4, 2'b10, 2'b11, 1'b0, 1'b1);
    e2(b + 8, 2'b10, 2'b01, 1'b0, 1'b1);
    e2(b + 12, 2'b10, 2'b01, 1'b0, 1'b0);
    tick(15);
    b = cyc; hold_req = 2'b00;
    e2(b + 1, 2'b11, 2'b01, 1'b0, 1'b1);
    e2(b + 5, 2'b11, 2'b00, 1'b0, 1'b1);
    e2(b + 9, 2'b11, 2'b00, 1'b1, 1'b0);
    tick(12);
    // Async reset mid-RUN, then restart.
    b = cyc;
    #2 reset = 1'b0; in_reset = 1'b1;
    #1 chk("async reset in RUN", snap2, 10'b00_00_00_11_0_0);
    e2(b + 1, 2'b00, 2'b11, 1'b0, 1'b0);
    tick(3);
    reset = 1'b1;
    tick(2);
    b = cyc; in_reset = 1'b0; bringup2(b);
    tick(22);
    // Async reset mid-G_ON_EN, then restart.
    b = cyc; hold_req = 2'b10;
    e2(b + 1, 2'b11, 2'b10, 1'b0, 1'b1);
    e2(b + 5, 2'b01, 2'b10, 1'b0, 1'b0);
    tick(7);
    d = cyc; hold_req = 2'b00;
    e2(d + 1, 2'b11, 2'b10, 1'b0, 1'b1);
    tick(2);
    b = cyc;
    #2 reset = 1'b0; in_reset = 1'b1;
    #1 chk("async reset in G_ON_EN", snap2, 10'b00_00_00_11_0_0);
    e2(b + 1, 2'b00, 2'b11, 1'b0, 1'b0);
    tick(3);
    reset = 1'b1;
    tick(2);
    b = cyc; in_reset = 1'b0; bringup2(b);
    tick(22);

    // Four groups, one-cycle stagger.
    b = cyc; in_reset4 = 1'b0;
    e4(b + 3, 4'b0001, 4'b1111, 1'b0, 1'b1);
    e4(b + 4, 4'b0001, 4'b1110, 1'b0, 1'b1);
    e4(b + 5, 4'b0011, 4'b1110, 1'b0, 1'b1);
    e4(b + 6, 4'b0011, 4'b1100, 1'b0, 1'b1);
    e4(b + 7, 4'b0111, 4'b1100, 1'b0, 1'b1);
    e4(b + 8, 4'b0111, 4'b1000, 1'b0, 1'b1);
    e4(b + 9, 4'b1111, 4'b1000, 1'b0, 1'b1);
    e4(b + 10, 4'b1111, 4'b0000, 1'b0, 1'b1);
    e4(b + 11, 4'b1111, 4'b0000, 1'b1, 1'b0);
    tick(13);
    b = cyc; hold_req4 = 4'b0100;
    e4(b + 1, 4'b1111, 4'b0100, 1'b0, 1'b1);
    e4(b + 2, 4'b1011, 4'b0100, 1'b0, 1'b0);
    tick(4);
    b = cyc; in_reset4 = 1'b1;
    e4(b + 3, 4'b1011, 4'b1111, 1'b0, 1'b1);
    e4(b + 4, 4'b0000, 4'b1111, 1'b0, 1'b0);
    tick(6);
    // Bring-up with group 2 skipped.
    b = cyc; in_reset4 = 1'b0;
    e4(b + 3, 4'b0001, 4'b1111, 1'b0, 1'b1);
    e4(b + 4, 4'b0001, 4'b1110, 1'b0, 1'b1);
    e4(b + 5, 4'b0011, 4'b1110, 1'b0, 1'b1);
    e4(b + 6, 4'b0011, 4'b1100, 1'b0, 1'b1);
    e4(b + 8, 4'b1011, 4'b1100, 1'b0, 1'b1);
    e4(b + 9, 4'b1011, 4'b0100, 1'b0, 1'b1);
    e4(b + 10, 4'b1011, 4'b0100, 1'b0, 1'b0);
    tick(13);

    chk("dut2 events pending", 10'(q2.size()), 10'd0);
    chk("dut4 events pending", 10'(q4.size()), 10'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
